// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer feeding a combinational 1-bit ALU slice.
// Streams WIDTH-bit operands LSB-first through the slice, registers the carry
// between bits and collects the result word, reported with a one-cycle done.
// Optional feature macro: ALU_SERIAL_OVF_EN (signed add overflow flag on ovf).
module alu_serial_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cin,
   output logic [7:0]       decoder_x,
   output logic             A_bit,
   output logic             B_bit,
   output logic             C_in_bit,
   input  logic             X_bit,
   input  logic             C_out_bit,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             err,
   output logic             ovf
);

   localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [2:0]  MODE_ADD = 3'd0;
   localparam logic [2:0]  MODE_MAX = 3'd4;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_nx;
   logic [WIDTH-1:0]   opa_sh, opb_sh;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         mode_q;
   logic               carry_q;
   logic               accept_c;
   logic               mode_ok_c;
   logic               last_c;

   assign accept_c  = (state_q == IDLE) && start;
   assign mode_ok_c = (mode <= MODE_MAX);
   assign last_c    = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

   // Slice operand bits come straight from the shift-register LSBs.
   assign A_bit    = opa_sh[0];
   assign B_bit    = opb_sh[0];
   assign C_in_bit = carry_q;

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (start) state_nx = mode_ok_c ? SHIFT : DONE;
         SHIFT:   if (last_c) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand capture, serial shift, result collection and status.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         opa_sh    <= '0;
         opb_sh    <= '0;
         cnt_q     <= '0;
         mode_q    <= '0;
         carry_q   <= 1'b0;
         decoder_x <= '0;
         result    <= '0;
         carry     <= 1'b0;
         err       <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state_nx == DONE);
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  mode_q <= mode;
                  cnt_q  <= '0;
                  result <= '0;
                  carry  <= 1'b0;
                  if (mode_ok_c) begin
                     opa_sh    <= opa;
                     opb_sh    <= opb;
                     carry_q   <= (mode == MODE_ADD) ? cin : 1'b0;
                     decoder_x <= 8'd1 << mode;
                     err       <= 1'b0;
                  end else begin
                     opa_sh    <= '0;
                     opb_sh    <= '0;
                     carry_q   <= 1'b0;
                     decoder_x <= '0;
                     err       <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               opa_sh  <= opa_sh >> 1;
               opb_sh  <= opb_sh >> 1;
               result  <= {X_bit, result[WIDTH-1:1]};
               carry_q <= C_out_bit;
               if (last_c) carry <= (mode_q == MODE_ADD) && C_out_bit;
               else        cnt_q <= cnt_q + CNT_W'(1);
            end
            DONE: begin
               carry_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SERIAL_OVF_EN
   // Overflow: carry into the MSB (C_in_bit on the final step) XOR carry out of it.
   always_ff @(posedge CLK) begin
      if (RESET)         ovf <= 1'b0;
      else if (accept_c) ovf <= 1'b0;
      else if (last_c)   ovf <= (mode_q == MODE_ADD) && (carry_q ^ C_out_bit);
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed vectors with a queue scoreboard; a behavioural
// 1-bit ALU slice is attached to the serial interface.
module tb_alu_serial_ctrl;

   localparam int unsigned WIDTH = 8;
`ifdef ALU_SERIAL_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RESET;
   logic             start;
   logic [2:0]       mode;
   logic [WIDTH-1:0] opa, opb;
   logic             cin;
   logic [7:0]       decoder_x;
   logic             A_bit, B_bit, C_in_bit;
   logic             X_bit, C_out_bit;
   logic             busy, done;
   logic [WIDTH-1:0] result;
   logic             carry, err, ovf;

   typedef struct {
      logic [7:0] res;
      logic       carry;
      logic       err;
      logic       ovf;
      logic [7:0] dec;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .mode(mode),
      .opa(opa), .opb(opb), .cin(cin), .decoder_x(decoder_x),
      .A_bit(A_bit), .B_bit(B_bit), .C_in_bit(C_in_bit),
      .X_bit(X_bit), .C_out_bit(C_out_bit), .busy(busy), .done(done),
      .result(result), .carry(carry), .err(err), .ovf(ovf)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Behavioural 1-bit ALU slice selected by the one-hot decoder bus.
   always_comb begin
      X_bit     = 1'b0;
      C_out_bit = 1'b0;
      if (decoder_x[0]) begin
         X_bit     = A_bit ^ B_bit ^ C_in_bit;
         C_out_bit = (A_bit & B_bit) | (A_bit & C_in_bit) | (B_bit & C_in_bit);
      end else if (decoder_x[1]) X_bit = A_bit & B_bit;
      else if (decoder_x[2])     X_bit = A_bit | B_bit;
      else if (decoder_x[3])     X_bit = A_bit ^ B_bit;
      else if (decoder_x[4])     X_bit = ~(A_bit ^ B_bit);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse pops one expected response.
   always @(negedge CLK) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("result", 32'(result), 32'(e.res));
            chk("carry", 32'(carry), 32'(e.carry));
            chk("err", 32'(err), 32'(e.err));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("decoder_x", 32'(decoder_x), 32'(e.dec));
         end
      end
   end

   // Issue one operation at the current negedge and wait for its done.
   task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [7:0] er, input logic ec,
                         input logic ee, input logic eo, input logic [7:0] ed);
      exp_t e;
      int   guard;
      e.res = er; e.carry = ec; e.err = ee; e.ovf = eo; e.dec = ed;
      e.cyc = cyc + (ee ? 1 : WIDTH + 1);
      sb.push_back(e);
      mode = m; opa = a; opb = b; cin = ci; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      #1;
      chk("busy_cycle1", 32'(busy), 32'd1);
      chk("dec_cycle1", 32'(decoder_x), 32'(ed));
      chk("err_cycle1", 32'(err), 32'(ee));
      chk("result_cycle1", 32'(result), 32'd0);
      if (!ee)
         chk("slice_bits_cycle1", 32'({A_bit, B_bit, C_in_bit}),
             32'({a[0], b[0], (m == 3'd0) ? ci : 1'b0}));
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         @(negedge CLK);
         #1;
         guard++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge CLK);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_idle", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      RESET = 1'b1; start = 1'b0; mode = '0; opa = '0; opb = '0; cin = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", 32'({carry, err, ovf}), 32'd0);
      chk("rst_decoder", 32'(decoder_x), 32'd0);
      chk("rst_slice_bits", 32'({A_bit, B_bit, C_in_bit}), 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      //      mode   a      b      cin   result carry err ovf     dec
      run_op(3'd0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 8'h01);
      run_op(3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01);
      run_op(3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, OVF_EN, 8'h01);
      run_op(3'd0, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01);
      run_op(3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, OVF_EN, 8'h01);
      run_op(3'd1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h02);
      run_op(3'd2, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 8'h04);
      run_op(3'd3, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h08);
      run_op(3'd4, 8'hAA, 8'hFF, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h10);
      run_op(3'd6, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      run_op(3'd0, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h01);
      run_op(3'd7, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);

      // start pulses in cycles 3 and 9 of an active add are ignored
      begin
         exp_t e;
         e.res = 8'h41; e.carry = 1'b0; e.err = 1'b0; e.ovf = 1'b0; e.dec = 8'h01;
         e.cyc = cyc + WIDTH + 1;
         sb.push_back(e);
         mode = 3'd0; opa = 8'h3C; opb = 8'h05; cin = 1'b0; start = 1'b1;
         @(negedge CLK); start = 1'b0;
         repeat (2) @(negedge CLK);
         start = 1'b1; mode = 3'd3; opa = 8'hFF; opb = 8'h00; cin = 1'b1;
         @(negedge CLK); start = 1'b0;
         repeat (5) @(negedge CLK);
         start = 1'b1; mode = 3'd1; opa = 8'h00; opb = 8'h00;
         #1;
         chk("busy_cycle9", 32'(busy), 32'd1);
         @(negedge CLK); start = 1'b0;
         #1;
         chk("busy_after_ignored", 32'(busy), 32'd0);
         chk("sb_after_ignored", 32'(sb.size()), 32'd0);
         chk("result_held", 32'(result), 32'h41);
         repeat (3) @(negedge CLK);
         chk("no_second_done", 32'(busy), 32'd0);
      end

      // reset in cycle 4 of an add aborts it; new start in cycle 5
      mode = 3'd0; opa = 8'hFF; opb = 8'hFF; cin = 1'b1; start = 1'b1;
      @(negedge CLK); start = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_flags", 32'({carry, err, ovf}), 32'd0);
      RESET = 1'b0;
      run_op(3'd0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 8'h01);

      repeat (3) @(negedge CLK);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
